// File: rtl/shift_deser.sv
`default_nettype none
// ============================================================================
//  Module   : shift_deser
//  Purpose  : Serial-in / parallel-out receiver. Collects one bit per clock on
//             which sin_valid is high into a WIDTH-bit word, MSB-first or
//             LSB-first (chosen per frame by dir on the first bit), and offers
//             each completed word on S through a valid/ready handshake.
//
//  Ports    :
//    clk        in   rising-edge clock
//    rstn       in   asynchronous active-low reset
//    sin        in   serial data bit
//    sin_valid  in   sin is taken on this edge when high
//    dir        in   0 = MSB-first (shift left), 1 = LSB-first (shift right)
//    S          out  last completed word
//    s_valid    out  S holds a word not yet accepted
//    s_ready    in   consumer accepts S when s_valid && s_ready
//    busy       out  a frame is partially received
//    overrun    out  sticky: an unaccepted word was overwritten
//    ovr_clr    in   synchronous clear of overrun (a same-edge set wins)
//    parity_err out  even-parity status of the last word (0 when disabled)
//
//  Options  : define SHIFT_DESER_PARITY_EN to append one even-parity bit to
//             every frame (adds the PAR state and a real parity_err).
//
//  Revision : 1.0  initial release
// ============================================================================
module shift_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] S,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             parity_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
`ifdef SHIFT_DESER_PARITY_EN
    localparam logic [1:0] c_ST_PAR   = 2'd2;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_frame_dir;
    logic [WIDTH-1:0]   r_s;
    logic               r_s_valid;
    logic               r_overrun;

    // ------------------------------------------------------------------------
    // Next-value logic
    // ------------------------------------------------------------------------
    logic             w_dir;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_data_last;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic             w_ovr_set;

    always_comb begin
        // The first bit of a frame must already use the incoming dir, since
        // frame_dir only becomes valid on the edge that takes that bit.
        w_dir       = (r_state == c_ST_IDLE) ? dir : r_frame_dir;
        w_sh_next   = w_dir ? {sin, r_sh[WIDTH-1:1]}
                            : {r_sh[WIDTH-2:0], sin};
        // The first bit is always taken in IDLE, so bit WIDTH (WIDTH >= 2)
        // is always taken in SHIFT with cnt == WIDTH-1.
        w_data_last = (r_state == c_ST_SHIFT) && (r_cnt == c_CNT_LAST);
`ifdef SHIFT_DESER_PARITY_EN
        // The word is already complete in r_sh; this edge takes parity only.
        w_complete  = sin_valid && (r_state == c_ST_PAR);
        w_word      = r_sh;
`else
        w_complete  = sin_valid && w_data_last;
        w_word      = w_sh_next;
`endif
        // Completion coinciding with an acceptance is a clean hand-over.
        w_ovr_set   = w_complete && r_s_valid && !s_ready;
    end

    // ------------------------------------------------------------------------
    // Frame state machine and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_frame_dir <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (sin_valid) begin
                        r_frame_dir <= dir;
                        r_sh        <= w_sh_next;
                        r_cnt       <= c_CNT_ONE;
                        r_state     <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (sin_valid) begin
                        r_sh <= w_sh_next;
                        if (w_data_last) begin
                            r_cnt   <= '0;
`ifdef SHIFT_DESER_PARITY_EN
                            r_state <= c_ST_PAR;
`else
                            r_state <= c_ST_IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
`ifdef SHIFT_DESER_PARITY_EN
                c_ST_PAR: begin
                    // Parity bit is checked but never shifted into the word.
                    if (sin_valid) begin
                        r_state <= c_ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output word and handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s       <= '0;
            r_s_valid <= 1'b0;
        end else if (w_complete) begin
            // A fresh word keeps s_valid high even if the old one was taken.
            r_s       <= w_word;
            r_s_valid <= 1'b1;
        end else if (r_s_valid && s_ready) begin
            r_s_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_parity_err <= 1'b0;
        end else if (w_complete) begin
            // Even parity: data XOR parity bit must be 0 for a good frame.
            r_parity_err <= (^r_sh) ^ sin;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign S       = r_s;
    assign s_valid = r_s_valid;
    assign busy    = (r_state != c_ST_IDLE);
    assign overrun = r_overrun;

endmodule
`default_nettype wire
